pes_demux_1_n: RTL and testbench
================================

# pes_demux_1_n

Parametrised, registered 1-to-N demultiplexer, successor to the fixed 1:8 demux. Routes a WIDTH-bit input word to one of CHANNELS output lanes, either by an externally driven select (manual mode) or by an internal round-robin sequencer that dwells DWELL cycles per lane (auto mode). Outputs are registered with per-lane valid strobes, so downstream blocks see clean one-cycle-latency data. The block sits between a single serial/test source and per-channel consumers in the demux test and bring-up path.

## Interface
- WIDTH, 1, data word width in bits (≥1)
- CHANNELS, 8, number of output lanes (2..256; need not be a power of two)
- DWELL, 16, cycles spent on each lane in auto mode (≥1)
- HOLD, 1, 1: unselected lanes retain their last word; 0: unselected lanes are driven to zero every cycle
- SEL_W (localparam), $clog2(CHANNELS), select width
- clk  input  1  sole clock, rising-edge
- reset  input  1  synchronous, active-high reset
- i  input  WIDTH  data word
- i_valid  input  1  i is valid this cycle
- mode  input  1  0 = MANUAL (sel_in), 1 = AUTO (round-robin)
- sel_in  input  SEL_W  lane select, used in MANUAL only
- o  output  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- o_valid  output  CHANNELS  one-hot (or zero) per-lane valid strobe
- cur_sel  output  SEL_W  lane currently selected (registered)
- wrap  output  1  one-cycle pulse when AUTO wraps from CHANNELS-1 to 0
- sel_err  output  1  sticky: an out-of-range sel_in was presented in MANUAL

## Operation
- One clock; reset is synchronous and active-high: on a rising clk edge with reset=1 all state clears regardless of other inputs.
- Reset values: o=0, o_valid=0, cur_sel=0, wrap=0, sel_err=0, dwell counter=0, state=MANUAL.
- State machine (two states, next state = mode each cycle):
  - MANUAL: cur_sel <= sel_in if sel_in < CHANNELS; otherwise cur_sel holds and sel_err <= 1. Dwell counter held at 0.
  - AUTO: dwell counter increments each cycle; at DWELL-1 it returns to 0 and cur_sel advances; cur_sel = CHANNELS-1 advances to 0 and wrap pulses in that same cycle. sel_in ignored.
  - MANUAL→AUTO: starts from current cur_sel, dwell counter 0 (full dwell on that lane). AUTO→MANUAL: dwell counter cleared; cur_sel follows sel_in from the next edge.
- Routing uses the registered cur_sel present during the cycle: if i_valid, o[cur_sel] <= i and o_valid <= one-hot(cur_sel); else o_valid <= 0.
- Unselected lanes: HOLD=1 keep value; HOLD=0 load zero. With HOLD=0 and i_valid=0, the selected lane also loads zero.
- sel_err clears only on reset.

## Timing
- Data latency: i sampled at edge t appears on o/o_valid after edge t (1 cycle).
- Select latency MANUAL: sel_in at edge t → cur_sel after edge t → routes data sampled at edge t+1 (2-cycle sel-to-route).
- AUTO: each lane selected exactly DWELL consecutive cycles; full cycle CHANNELS*DWELL; wrap high for exactly one cycle per lap, coincident with cur_sel becoming 0.
- DWELL=1: cur_sel advances every cycle.
- Reset asserted mid-dwell or mid-lap: next cycle identical to post-reset state; no wrap pulse generated by reset.
- Mode change and i_valid in same cycle: data routes by cur_sel before the edge.

## Structure
- Package pes_demux_pkg: mode encoding constants (MODE_MANUAL=0, MODE_AUTO=1), state typedef, helper function for one-hot of a select value.
- Sub-module pes_demux_sel_seq: state, dwell counter, cur_sel, wrap, sel_err. Top level instantiates it plus the lane register array (generate loop over CHANNELS).

## Test plan
- Reset: drive random i/sel_in with reset=1 for 3 cycles → all outputs 0, cur_sel=0; after release with mode=0, sel_in=5, i=1, i_valid=1 → o[5]=1, o_valid=8'b0010_0000 two cycles later.
- AUTO sweep, CHANNELS=8, DWELL=4, i_valid=1, i toggling → cur_sel 0..7 each held 4 cycles, wrap high once at cycle 32, o_valid tracks cur_sel.
- Non-power-of-two, CHANNELS=5: AUTO → cur_sel sequence 0,1,2,3,4,0; MANUAL sel_in=6 → cur_sel unchanged, sel_err=1 and stays 1 until reset.
- HOLD: HOLD=1, write 1 to lane 2 then select lane 3 → o[2] stays 1; HOLD=0 same stimulus → o[2]=0 one cycle after lane 3 selected.
- Reset mid-operation: AUTO, assert reset at cur_sel=6, dwell=2 → next cycle cur_sel=0, dwell=0, state MANUAL, wrap=0.
- Mode switch: AUTO at cur_sel=3 dwell=1, switch to MANUAL sel_in=0 → cur_sel=0 next edge; back to AUTO → lane 0 held full DWELL before advancing.

Source files
------------

// File: rtl/pes_demux_pkg.sv
// Shared encodings and helpers for the 1-to-N demultiplexer.
package pes_demux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int unsigned MAX_CHANNELS = 256;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    function automatic logic [MAX_CHANNELS-1:0] sel_onehot(input logic [7:0] sel);
        logic [MAX_CHANNELS-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pes_demux_sel_seq.sv
// Lane-select sequencer: manual select with range check, or round-robin
// auto mode dwelling DWELL cycles per lane with a wrap pulse per lap.
module pes_demux_sel_seq
    import pes_demux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 8,
    parameter  int unsigned DWELL    = 16,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_in,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap,
    output logic             sel_err
);

    localparam int unsigned      DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   CH_LIMIT   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(CHANNELS - 1);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             wrap_q, wrap_d;
    logic             sel_err_q, sel_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_MANUAL;
            cur_sel_q <= '0;
            dwell_q   <= '0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            dwell_q   <= dwell_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        state_d   = (mode == MODE_AUTO) ? ST_AUTO : ST_MANUAL;
        cur_sel_d = cur_sel_q;
        dwell_d   = '0;
        wrap_d    = 1'b0;
        sel_err_d = sel_err_q;
        if (state_d == ST_MANUAL) begin
            if ({1'b0, sel_in} < CH_LIMIT) begin
                cur_sel_d = sel_in;
            end else begin
                sel_err_d = 1'b1;
            end
        end else if (state_q == ST_AUTO) begin
            if (dwell_q == DWELL_LAST) begin
                if (cur_sel_q == LAST_SEL) begin
                    cur_sel_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_sel_d = cur_sel_q + SEL_W'(1);
                end
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
        // First AUTO edge after MANUAL keeps lane and zero dwell, giving that lane a full dwell.
    end

    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: rtl/pes_demux_1_n.sv
// Registered 1-to-N demultiplexer: routes i to the lane chosen by the
// sequencer, with per-lane valid strobes and optional hold of idle lanes.
module pes_demux_1_n
    import pes_demux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 1,
    parameter  int unsigned CHANNELS = 8,
    parameter  int unsigned DWELL    = 16,
    parameter  int unsigned HOLD     = 1,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          i,
    input  logic                      i_valid,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [CHANNELS*WIDTH-1:0] o,
    output logic [CHANNELS-1:0]       o_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      wrap,
    output logic                      sel_err
);

    logic [CHANNELS-1:0] lane_hit;
    logic [CHANNELS-1:0] o_valid_q;

    pes_demux_sel_seq #(
        .CHANNELS(CHANNELS),
        .DWELL   (DWELL)
    ) u_seq (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .sel_in (sel_in),
        .cur_sel(cur_sel),
        .wrap   (wrap),
        .sel_err(sel_err)
    );

    // Routing uses the registered select, so a select change lands one edge later.
    assign lane_hit = CHANNELS'(sel_onehot(8'(cur_sel)));

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid_q <= '0;
        end else begin
            o_valid_q <= i_valid ? lane_hit : '0;
        end
    end

    assign o_valid = o_valid_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [WIDTH-1:0] lane_q, lane_d;

        always_comb begin
            lane_d = lane_q;
            if (i_valid && lane_hit[k]) begin
                lane_d = i;
            end else if (HOLD == 0) begin
                lane_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign o[k*WIDTH +: WIDTH] = lane_q;
    end

endmodule

// File: tb/tb_pes_demux_1_n.sv
// Directed bench for pes_demux_1_n: three instances (8 lanes/dwell 4/hold,
// 5 lanes/dwell 2/hold, 8 lanes/dwell 1/no hold) share one stimulus stream.
module tb_pes_demux_1_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] din = '0;
    logic [2:0] sel_in = '0;

    logic [31:0] oA;  logic [7:0] vA;  logic [2:0] selA;  logic wrapA, errA;
    logic [19:0] oB;  logic [4:0] vB;  logic [2:0] selB;  logic wrapB, errB;
    logic [31:0] oC;  logic [7:0] vC;  logic [2:0] selC;  logic wrapC, errC;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pes_demux_1_n #(.WIDTH(4), .CHANNELS(8), .DWELL(4), .HOLD(1)) dut_a (
        .clk(clk), .reset(reset), .i(din), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o(oA), .o_valid(vA), .cur_sel(selA), .wrap(wrapA), .sel_err(errA));

    pes_demux_1_n #(.WIDTH(4), .CHANNELS(5), .DWELL(2), .HOLD(1)) dut_b (
        .clk(clk), .reset(reset), .i(din), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o(oB), .o_valid(vB), .cur_sel(selB), .wrap(wrapB), .sel_err(errB));

    pes_demux_1_n #(.WIDTH(4), .CHANNELS(8), .DWELL(1), .HOLD(0)) dut_c (
        .clk(clk), .reset(reset), .i(din), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o(oC), .o_valid(vC), .cur_sel(selC), .wrap(wrapC), .sel_err(errC));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; i_valid = 1'b0; din = '0; sel_in = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            din = 4'($urandom); sel_in = 3'($urandom); mode = 1'($urandom); i_valid = 1'($urandom);
            step();
        end
        checks++; if (oA !== 32'h0) begin failures++; $display("FAIL reset_o: got %h want 0", oA); end
        checks++; if (vA !== 8'h0) begin failures++; $display("FAIL reset_ovalid: got %h want 0", vA); end
        checks++; if (selA !== 3'd0) begin failures++; $display("FAIL reset_cursel: got %0d want 0", selA); end
        checks++; if (wrapA !== 1'b0) begin failures++; $display("FAIL reset_wrap: got %b want 0", wrapA); end
        checks++; if (errA !== 1'b0 || errB !== 1'b0) begin failures++; $display("FAIL reset_selerr: got %b%b want 00", errA, errB); end
        reset = 1'b0; mode = 1'b0; sel_in = 3'd5; din = 4'h1; i_valid = 1'b1;
        step();
        checks++; if (selA !== 3'd5) begin failures++; $display("FAIL sel_latency: got %0d want 5", selA); end
        checks++; if (vA !== 8'h01) begin failures++; $display("FAIL route_old_sel: got %b want 00000001", vA); end
        step();
        checks++; if (vA !== 8'b0010_0000) begin failures++; $display("FAIL route_lane5_valid: got %b want 00100000", vA); end
        checks++; if (oA[23:20] !== 4'h1) begin failures++; $display("FAIL route_lane5_data: got %h want 1", oA[23:20]); end
    endtask

    task automatic test_auto_sweep();
        int pa, ea, eb, ec;
        logic [7:0] ev;
        do_reset();
        mode = 1'b1; i_valid = 1'b1;
        for (int n = 0; n < 36; n++) begin
            din = 4'(n);
            step();
            ea = (n / 4) % 8;
            pa = (n == 0) ? 0 : ((n - 1) / 4) % 8;
            eb = (n / 2) % 5;
            ec = n % 8;
            ev = 8'(1) << pa;
            checks++; if (selA !== 3'(ea)) begin failures++; $display("FAIL sweep_sel_a n=%0d: got %0d want %0d", n, selA, ea); end
            checks++; if (wrapA !== (n == 32)) begin failures++; $display("FAIL sweep_wrap_a n=%0d: got %b want %b", n, wrapA, (n == 32)); end
            checks++; if (vA !== ev) begin failures++; $display("FAIL sweep_valid_a n=%0d: got %b want %b", n, vA, ev); end
            checks++; if (oA[pa*4 +: 4] !== 4'(n)) begin failures++; $display("FAIL sweep_data_a n=%0d: got %h want %h", n, oA[pa*4 +: 4], 4'(n)); end
            checks++; if (selB !== 3'(eb)) begin failures++; $display("FAIL sweep_sel_b n=%0d: got %0d want %0d", n, selB, eb); end
            checks++; if (wrapB !== (n > 0 && n % 10 == 0)) begin failures++; $display("FAIL sweep_wrap_b n=%0d: got %b", n, wrapB); end
            checks++; if (selC !== 3'(ec)) begin failures++; $display("FAIL sweep_sel_c n=%0d: got %0d want %0d", n, selC, ec); end
            checks++; if (wrapC !== (n > 0 && n % 8 == 0)) begin failures++; $display("FAIL sweep_wrap_c n=%0d: got %b", n, wrapC); end
        end
    endtask

    task automatic test_sel_err();
        do_reset();
        mode = 1'b0; i_valid = 1'b0;
        sel_in = 3'd4; step();
        checks++; if (selB !== 3'd4 || errB !== 1'b0) begin failures++; $display("FAIL err_last_valid: got sel=%0d err=%b want 4/0", selB, errB); end
        sel_in = 3'd5; step();
        checks++; if (selB !== 3'd4 || errB !== 1'b1) begin failures++; $display("FAIL err_eq_channels: got sel=%0d err=%b want 4/1", selB, errB); end
        sel_in = 3'd6; step();
        checks++; if (selB !== 3'd4 || errB !== 1'b1) begin failures++; $display("FAIL err_sel6: got sel=%0d err=%b want 4/1", selB, errB); end
        checks++; if (selA !== 3'd6 || errA !== 1'b0) begin failures++; $display("FAIL err_a_inrange: got sel=%0d err=%b want 6/0", selA, errA); end
        sel_in = 3'd1; step();
        checks++; if (selB !== 3'd1 || errB !== 1'b1) begin failures++; $display("FAIL err_sticky: got sel=%0d err=%b want 1/1", selB, errB); end
        mode = 1'b1; repeat (3) step();
        checks++; if (errB !== 1'b1) begin failures++; $display("FAIL err_sticky_auto: got %b want 1", errB); end
        do_reset();
        checks++; if (errB !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b want 0", errB); end
    endtask

    task automatic test_hold();
        do_reset();
        sel_in = 3'd2; step();
        din = 4'h1; i_valid = 1'b1; sel_in = 3'd3; step();
        checks++; if (oA[11:8] !== 4'h1 || oC[11:8] !== 4'h1) begin failures++; $display("FAIL hold_write2: got %h/%h want 1/1", oA[11:8], oC[11:8]); end
        din = 4'h7; step();
        checks++; if (oA[11:8] !== 4'h1) begin failures++; $display("FAIL hold1_lane2: got %h want 1", oA[11:8]); end
        checks++; if (oA[15:12] !== 4'h7) begin failures++; $display("FAIL hold1_lane3: got %h want 7", oA[15:12]); end
        checks++; if (oC[11:8] !== 4'h0) begin failures++; $display("FAIL hold0_lane2: got %h want 0", oC[11:8]); end
        checks++; if (oC[15:12] !== 4'h7) begin failures++; $display("FAIL hold0_lane3: got %h want 7", oC[15:12]); end
        i_valid = 1'b0; step();
        checks++; if (oA[15:12] !== 4'h7 || vA !== 8'h0) begin failures++; $display("FAIL hold1_idle: got %h v=%h want 7 v=0", oA[15:12], vA); end
        checks++; if (oC[15:12] !== 4'h0 || vC !== 8'h0) begin failures++; $display("FAIL hold0_idle: got %h v=%h want 0 v=0", oC[15:12], vC); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 1'b1; i_valid = 1'b1; din = 4'hA;
        step();
        repeat (26) step();
        checks++; if (selA !== 3'd6) begin failures++; $display("FAIL mid_setup: got %0d want 6", selA); end
        reset = 1'b1; step();
        checks++; if (selA !== 3'd0 || wrapA !== 1'b0) begin failures++; $display("FAIL mid_reset: got sel=%0d wrap=%b want 0/0", selA, wrapA); end
        checks++; if (vA !== 8'h0 || oA !== 32'h0) begin failures++; $display("FAIL mid_reset_out: got v=%h o=%h want 0/0", vA, oA); end
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step();
            checks++; if (selA !== ((r == 4) ? 3'd1 : 3'd0) || wrapA !== 1'b0) begin failures++; $display("FAIL mid_restart r=%0d: got sel=%0d wrap=%b", r, selA, wrapA); end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1; i_valid = 1'b0;
        step();
        repeat (13) step();
        checks++; if (selA !== 3'd3) begin failures++; $display("FAIL sw_setup: got %0d want 3", selA); end
        mode = 1'b0; sel_in = 3'd0; i_valid = 1'b1; din = 4'h9;
        step();
        checks++; if (selA !== 3'd0) begin failures++; $display("FAIL sw_to_manual: got %0d want 0", selA); end
        checks++; if (vA !== 8'b0000_1000 || oA[15:12] !== 4'h9) begin failures++; $display("FAIL sw_route_old: got v=%b d=%h want 00001000/9", vA, oA[15:12]); end
        mode = 1'b1; i_valid = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step();
            checks++; if (selA !== ((r == 4) ? 3'd1 : 3'd0)) begin failures++; $display("FAIL sw_full_dwell r=%0d: got %0d", r, selA); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_auto_sweep();
        test_sel_err();
        test_hold();
        test_reset_mid();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
